cp0_exception_unit: RTL and testbench
=====================================

// Module: cp0_exception_unit
// PURPOSE
//  Coprocessor-0 exception front end of the MIPS core. Captures EPC, Cause and Status on an exception or interrupt.
//  Drives pipeline flush and a PC redirect to the handler vector; returns to EPC on ERET.
//  Feeds epc4 (captured EPC + 4) to the downstream EPC+8 adder; also serves MFC0/MTC0 accesses.
// PARAMETERS
//  EXC_VECTOR    32'h0000_0180  handler entry address driven on redirect
//  FLUSH_CYCLES  2              cycles flush is held before redirect (>=1)
// PORTS
//  clk            in   1   core clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  exc_req        in   1   synchronous exception from EX stage (level, sampled per cycle)
//  exc_code       in   5   MIPS ExcCode of exc_req
//  exc_pc         in   32  PC of faulting instruction
//  in_delay_slot  in   1   faulting instruction sits in a branch delay slot
//  int_req        in   1   external interrupt request (level)
//  eret           in   1   ERET decoded in EX
//  cp0_we         in   1   MTC0 write strobe
//  cp0_addr       in   5   CP0 register number (read and write)
//  cp0_wdata      in   32  MTC0 data
//  cp0_rdata      out  32  MFC0 data, combinational from cp0_addr
//  flush          out  1   squash IF/ID/EX
//  pc_redirect    out  1   one-cycle strobe: PC <= redirect_pc
//  redirect_pc    out  32  target address, valid when pc_redirect=1
//  epc4           out  32  registered epc_q + 4
//  status_exl     out  1   exception level bit
//  exc_dropped    out  1   one-cycle pulse: request arrived while busy, ignored
// BEHAVIOUR
//  Reset (async): state=IDLE; epc_q=0; epc4=32'd4; cause=0; status=0 (IE=0, EXL=0); flush=0; pc_redirect=0; redirect_pc=0; exc_dropped=0.
//  FSM states IDLE, FLUSH, REDIRECT, HANDLER, RETURN:
//   IDLE: exc_req=1 -> capture, FLUSH. Otherwise int_req & IE & !EXL -> capture with code 0, FLUSH. exc_req has priority over int_req.
//   Capture (one edge): epc_q = in_delay_slot ? exc_pc-4 : exc_pc; cause[31]=in_delay_slot; cause[6:2]=code; EXL=1; epc4 = new epc_q + 4 (mod 2^32).
//   FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (counter), then REDIRECT.
//   REDIRECT: pc_redirect=1 and redirect_pc=EXC_VECTOR for one cycle; flush stays 1 this cycle; then HANDLER.
//   HANDLER: eret=1 -> RETURN. exc_req or int_req -> exc_dropped pulse; EPC/Cause unchanged.
//   RETURN: pc_redirect=1 and redirect_pc=epc_q for one cycle; flush=1; EXL cleared on the exit edge; -> IDLE.
//  Latency: exception-capture edge to pc_redirect = FLUSH_CYCLES+1 cycles.
//  ERET in IDLE/FLUSH/REDIRECT: ignored, no output change.
//  exc_req in FLUSH/REDIRECT/RETURN: exc_dropped pulse.
//  MTC0: reg 12 writes status[0] (IE) only; reg 14 writes epc_q and epc4. MTC0 to other registers is ignored.
//  A same-cycle capture beats MTC0.
//  MFC0: 12 -> {30'b0,EXL,IE}; 13 -> cause; 14 -> epc_q; others -> 0.
//  Arithmetic: all 32-bit unsigned, wrap-around (exc_pc=0 in slot gives epc_q=32'hFFFF_FFFC).
//  Reset mid-sequence aborts immediately to reset values; no redirect is emitted.
// CONFIGURATION
//  CP0_BADVADDR_EN defined: adds input bad_vaddr[31:0] and a badvaddr_q register (reg 8).
//   - Loaded on capture when exc_code is 4 or 5 (AdEL/AdES); reset 0; read-only via MFC0.
//  Not defined: no bad_vaddr port; reg 8 reads 0.
// STRUCTURE
//  Shared package cp0_pkg: state encodings; CP0 register numbers (8/12/13/14); ExcCode constants.
//  Package also holds the Cause/Status bit positions.
//  One sub-module: cp0_exc_fsm (state register + flush counter). The top holds CP0 registers and the read mux.
// TESTING
//  exc_req, code=12, exc_pc=32'h0040_0010, slot=0 -> flush held 2 cycles; then pc_redirect with 32'h180; epc4=32'h0040_0014; cause[6:2]=12.
//  Delay-slot exc, exc_pc=32'h0040_0020 -> epc_q=32'h0040_001C, cause[31]=1, epc4=32'h0040_0020.
//  IE=1 via MTC0 12, int_req=1, exc_req=1 same cycle -> exc code captured; then int_req in HANDLER -> exc_dropped pulse.
//  HANDLER then eret -> one-cycle pc_redirect to epc_q; EXL=0 next cycle; MFC0 12 reads 1.
//  rst asserted during FLUSH -> outputs reset asynchronously, no pc_redirect; exc_pc=0 in slot -> epc_q=32'hFFFF_FFFC, epc4=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: FSM state encoding, CP0 register numbers,
// ExcCode constants, Cause/Status bit positions and a Cause builder.
package cp0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN
  } cp0_state_e;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int unsigned CAUSE_BD_BIT    = 31;
  localparam int unsigned CAUSE_CODE_LO   = 2;
  localparam int unsigned CAUSE_CODE_HI   = 6;
  localparam int unsigned STATUS_IE_BIT   = 0;
  localparam int unsigned STATUS_EXL_BIT  = 1;

  function automatic logic [31:0] make_cause(input logic bd, input logic [4:0] code);
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD_BIT] = bd;
    c[CAUSE_CODE_HI:CAUSE_CODE_LO] = code;
    return c;
  endfunction

endpackage

// File: rtl/cp0_exc_fsm.sv
// Exception sequencing FSM: IDLE -> FLUSH (FLUSH_CYCLES) -> REDIRECT ->
// HANDLER -> (eret) RETURN -> IDLE, with the flush-length counter.
module cp0_exc_fsm
  import cp0_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eret,
  output cp0_state_e state,
  output logic       flush,
  output logic       redirect_exc,
  output logic       redirect_ret
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);

  cp0_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and flush-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; counter restarts on every capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_LAST) state_d = ST_REDIRECT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_REDIRECT: state_d = ST_HANDLER;
      ST_HANDLER:  if (eret) state_d = ST_RETURN;
      ST_RETURN:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    flush        = 1'b0;
    redirect_exc = 1'b0;
    redirect_ret = 1'b0;
    case (state_q)
      ST_FLUSH:    flush = 1'b1;
      ST_REDIRECT: begin flush = 1'b1; redirect_exc = 1'b1; end
      ST_RETURN:   begin flush = 1'b1; redirect_ret = 1'b1; end
      default:     ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception front end: EPC/Cause/Status capture, flush and PC redirect
// sequencing, ERET return, MFC0/MTC0 access.
// Optional feature macro CP0_BADVADDR_EN adds bad_vaddr input and BadVAddr (reg 8).
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        in_delay_slot,
  input  logic        int_req,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] bad_vaddr,
`endif
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc4,
  output logic        status_exl,
  output logic        exc_dropped
);

  cp0_state_e  state;
  logic        fsm_flush, redir_exc, redir_ret;
  logic        capture;
  logic [4:0]  cap_code;
  logic [31:0] cap_epc;
  logic        ie_q, exl_q;
  logic [31:0] epc_q, epc4_q, cause_q;

  cp0_exc_fsm #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start        (capture),
    .eret         (eret),
    .state        (state),
    .flush        (fsm_flush),
    .redirect_exc (redir_exc),
    .redirect_ret (redir_ret)
  );

  assign capture  = (state == ST_IDLE) && (exc_req || (int_req && ie_q && !exl_q));
  assign cap_code = exc_req ? exc_code : EXC_INT;
  assign cap_epc  = in_delay_slot ? (exc_pc - 32'd4) : exc_pc;

  // CP0 register file; a capture in the same cycle suppresses any MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q   <= '0;
      epc4_q  <= 32'd4;
      cause_q <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
    end else if (capture) begin
      epc_q   <= cap_epc;
      epc4_q  <= cap_epc + 32'd4;
      cause_q <= make_cause(in_delay_slot, cap_code);
      exl_q   <= 1'b1;
    end else begin
      if (cp0_we && cp0_addr == CP0_REG_STATUS) ie_q <= cp0_wdata[STATUS_IE_BIT];
      if (cp0_we && cp0_addr == CP0_REG_EPC) begin
        epc_q  <= cp0_wdata;
        epc4_q <= cp0_wdata + 32'd4;
      end
      if (state == ST_RETURN) exl_q <= 1'b0;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;

  // BadVAddr latches only on address-error exceptions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) badvaddr_q <= '0;
    else if (capture && exc_req && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
      badvaddr_q <= bad_vaddr;
  end
`endif

  // Requests that arrive while a sequence is in flight are reported and ignored
  always_comb begin
    exc_dropped = 1'b0;
    case (state)
      ST_HANDLER:                      exc_dropped = exc_req | int_req;
      ST_FLUSH, ST_REDIRECT, ST_RETURN: exc_dropped = exc_req;
      default:                         exc_dropped = 1'b0;
    endcase
  end

  // Redirect target selection
  always_comb begin
    redirect_pc = '0;
    if (redir_exc)      redirect_pc = EXC_VECTOR;
    else if (redir_ret) redirect_pc = epc_q;
  end

  // MFC0 read mux
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_REG_STATUS: begin
        cp0_rdata[STATUS_IE_BIT]  = ie_q;
        cp0_rdata[STATUS_EXL_BIT] = exl_q;
      end
      CP0_REG_CAUSE: cp0_rdata = cause_q;
      CP0_REG_EPC:   cp0_rdata = epc_q;
`ifdef CP0_BADVADDR_EN
      CP0_REG_BADVADDR: cp0_rdata = badvaddr_q;
`endif
      default:       cp0_rdata = '0;
    endcase
  end

  assign flush       = fsm_flush;
  assign pc_redirect = redir_exc | redir_ret;
  assign epc4        = epc4_q;
  assign status_exl  = exl_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: a driver issues directed then
// random cycles and pushes expectations from a cycle-count reference model;
// an independent monitor pops and compares at mid-cycle.
module tb_cp0_exception_unit;

  localparam logic [31:0] VEC = 32'h0000_0180;
  localparam int FC = 2;

  logic        clk, rst;
  logic        exc_req, in_delay_slot, int_req, eret, cp0_we;
  logic [4:0]  exc_code, cp0_addr;
  logic [31:0] exc_pc, cp0_wdata;
  logic [31:0] cp0_rdata, redirect_pc, epc4;
  logic        flush, pc_redirect, status_exl, exc_dropped;
`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;
`endif

  cp0_exception_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .exc_pc        (exc_pc),
    .in_delay_slot (in_delay_slot),
    .int_req       (int_req),
    .eret          (eret),
    .cp0_we        (cp0_we),
    .cp0_addr      (cp0_addr),
    .cp0_wdata     (cp0_wdata),
`ifdef CP0_BADVADDR_EN
    .bad_vaddr     (bad_vaddr),
`endif
    .cp0_rdata     (cp0_rdata),
    .flush         (flush),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .epc4          (epc4),
    .status_exl    (status_exl),
    .exc_dropped   (exc_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        redir;
    logic        drop;
    logic        exl;
    logic [31:0] epc4;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: cycles since capture (0 = not sequencing), handler and
  // return flags, and the architectural register contents.
  int          m_k;
  bit          m_handler, m_ret, m_ie, m_exl;
  logic [31:0] m_epc, m_cause, m_bad;

  task automatic model_reset();
    m_k = 0; m_handler = 0; m_ret = 0; m_ie = 0; m_exl = 0;
    m_epc = '0; m_cause = '0; m_bad = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return {30'd0, m_exl, m_ie};
      5'd13: return m_cause;
      5'd14: return m_epc;
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bad;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic do_cycle(input bit r, input bit e, input logic [4:0] code,
                          input logic [31:0] pc, input bit slot, input bit irq,
                          input bit er, input bit we, input logic [4:0] addr,
                          input logic [31:0] wd, input logic [31:0] bv);
    exp_t        x;
    bit          cap;
    logic [31:0] ne;
    @(negedge clk);
    rst = r; exc_req = e; exc_code = code; exc_pc = pc; in_delay_slot = slot;
    int_req = irq; eret = er; cp0_we = we; cp0_addr = addr; cp0_wdata = wd;
`ifdef CP0_BADVADDR_EN
    bad_vaddr = bv;
`endif
    if (r) model_reset();
    x.flush = (m_k > 0) || m_ret;
    x.redir = (m_k == FC + 1) || m_ret;
    x.drop  = m_handler ? (e || irq) : (((m_k > 0) || m_ret) ? e : 1'b0);
    x.exl   = m_exl;
    x.epc4  = m_epc + 32'd4;
    x.rdata = m_read(addr);
    exp_q.push_back(x);
    if (x.redir) redir_q.push_back(m_ret ? m_epc : VEC);
    if (!r) begin
      cap = (m_k == 0) && !m_handler && !m_ret && (e || (irq && m_ie && !m_exl));
      if (cap) begin
        ne = slot ? pc - 32'd4 : pc;
        m_epc = ne;
        m_cause = '0;
        m_cause[31] = slot;
        m_cause[6:2] = e ? code : 5'd0;
        m_exl = 1;
        m_k = 1;
        if (e && (code == 5'd4 || code == 5'd5)) m_bad = bv;
      end else begin
        if (m_k > 0) begin
          if (m_k == FC + 1) begin m_k = 0; m_handler = 1; end
          else m_k++;
        end else if (m_handler) begin
          if (er) begin m_handler = 0; m_ret = 1; end
        end else if (m_ret) begin
          m_ret = 0; m_exl = 0;
        end
        if (we && addr == 5'd12) m_ie = wd[0];
        if (we && addr == 5'd14) m_epc = wd;
      end
    end
  endtask

  task automatic quiet(input int n, input logic [4:0] addr, input bit irq);
    for (int i = 0; i < n; i++)
      do_cycle(0, 0, 5'd0, 32'd0, 0, irq, 0, 0, addr, 32'd0, 32'd0);
  endtask

  // Monitor: compares the DUT against the queued expectations each cycle
  exp_t mx;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        check("flush",       {31'd0, flush},       {31'd0, mx.flush});
        check("pc_redirect", {31'd0, pc_redirect}, {31'd0, mx.redir});
        check("exc_dropped", {31'd0, exc_dropped}, {31'd0, mx.drop});
        check("status_exl",  {31'd0, status_exl},  {31'd0, mx.exl});
        check("epc4",        epc4,                 mx.epc4);
        check("cp0_rdata",   cp0_rdata,            mx.rdata);
      end
      if (pc_redirect === 1'b1) begin
        if (redir_q.size() == 0) check("unexpected_redirect", redirect_pc, 32'hxxxx_xxxx);
        else check("redirect_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    logic [4:0] ra;
    rst = 1'b1; exc_req = 0; exc_code = '0; exc_pc = '0; in_delay_slot = 0;
    int_req = 0; eret = 0; cp0_we = 0; cp0_addr = '0; cp0_wdata = '0;
`ifdef CP0_BADVADDR_EN
    bad_vaddr = '0;
`endif
    model_reset();
    do_cycle(1, 0, 5'd0, 32'd0, 0, 0, 0, 0, 5'd12, 32'd0, 32'd0);
    do_cycle(1, 0, 5'd0, 32'd0, 0, 0, 0, 0, 5'd14, 32'd0, 32'd0);
    // IE=1, then exception and interrupt in the same cycle
    do_cycle(0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 5'd12, 32'd1, 32'd0);
    do_cycle(0, 1, 5'd12, 32'h0040_0010, 0, 1, 0, 0, 5'd13, 32'd0, 32'd0);
    quiet(3, 5'd13, 1);
    quiet(2, 5'd14, 1);
    do_cycle(0, 0, 5'd0, 32'd0, 0, 0, 1, 0, 5'd14, 32'd0, 32'd0);
    quiet(3, 5'd12, 0);
    // Delay-slot exception with ERET ignored while flushing
    do_cycle(0, 1, 5'd10, 32'h0040_0020, 1, 0, 0, 0, 5'd13, 32'd0, 32'd0);
    do_cycle(0, 1, 5'd3, 32'd0, 0, 0, 1, 0, 5'd14, 32'd0, 32'd0);
    quiet(3, 5'd13, 0);
    do_cycle(0, 0, 5'd0, 32'd0, 0, 0, 1, 0, 5'd14, 32'd0, 32'd0);
    quiet(2, 5'd12, 0);
    // Wrap-around EPC, then reset in the middle of the flush
    do_cycle(0, 1, 5'd4, 32'd0, 1, 0, 0, 0, 5'd14, 32'd0, 32'h1234_5678);
    quiet(1, 5'd14, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 0, 0, 0, 0, 5'd14, 32'd0, 32'd0);
    quiet(4, 5'd12, 0);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 5'd8;
        1: ra = 5'd12;
        2: ra = 5'd13;
        3: ra = 5'd14;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      do_cycle($urandom_range(0, 299) == 0,
               $urandom_range(0, 5) == 0,
               5'($urandom_range(0, 31)),
               ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0,
               ra,
               32'($urandom),
               32'($urandom));
    end
    quiet(1, 5'd0, 0);
    #4;
    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("redirect_queue_drained", redir_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
